// File: rtl/rot_pkg.sv
// Shared constants and the rotate-direction type used by the rot_stream slice.
package rot_pkg;
  localparam int N_DEF     = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic {
    ROT_RIGHT = 1'b0,
    ROT_LEFT  = 1'b1
  } rot_dir_e;
endpackage

// File: rtl/rot_core.sv
// Purely combinational rotate-right: dout[i] = din[(i + amt) mod N].
module rot_core #(
  parameter int N = 8
) (
  input  logic [N-1:0]         din,
  input  logic [$clog2(N)-1:0] amt,
  output logic [N-1:0]         dout
);
  logic [2*N-1:0] dbl;

  // Shifting the doubled word right brings the wrapped bits in from the upper copy.
  assign dbl  = {din, din} >> amt;
  assign dout = dbl[N-1:0];
endmodule

// File: rtl/rot_stream.sv
// Valid/ready rotate stream: command FIFO -> rot_core -> output register.
// Define ROT_STREAM_LEFT_EN to add the in_dir port (per-entry left/right selection).
module rot_stream
  import rot_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_data,
  input  logic [$clog2(N)-1:0]   in_amt,
`ifdef ROT_STREAM_LEFT_EN
  input  logic                   in_dir,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(N);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [N-1:0]  data;
    logic [AW-1:0] amt;
    rot_dir_e      dir;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          cmd_in;
  cmd_t          head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push;
  logic          pop;
  logic [AW-1:0] amt_eff;
  logic [N-1:0]  rot_data;

  assign cmd_in.data = in_data;
  assign cmd_in.amt  = in_amt;
`ifdef ROT_STREAM_LEFT_EN
  assign cmd_in.dir  = rot_dir_e'(in_dir);
`else
  assign cmd_in.dir  = ROT_RIGHT;
`endif

  assign in_ready = (count < (PW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!out_valid || out_ready);
  assign head     = mem[rptr];

  // Left by k equals right by (N - k) mod N; truncation to AW bits gives the mod.
  assign amt_eff = (head.dir == ROT_LEFT) ? AW'(N - int'(head.amt)) : head.amt;

  rot_core #(.N(N)) u_core (
    .din  (head.data),
    .amt  (amt_eff),
    .dout (rot_data)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= cmd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= rot_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rot_stream.sv
// Self-checking bench for rot_stream (N=8, DEPTH=4) with a queue-based reference model.
module tb_rot_stream;
  localparam int N     = 8;
  localparam int DEPTH = 4;
`ifdef ROT_STREAM_LEFT_EN
  localparam bit LEFT_EN = 1'b1;
`else
  localparam bit LEFT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic [2:0]   in_amt = '0;
  logic         in_dir = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_data;
  logic [2:0]   count;

  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] q[$];

  always #5 clk = ~clk;

  rot_stream #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
`ifdef ROT_STREAM_LEFT_EN
    .in_dir    (in_dir),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Reference: bit i of a right rotation is d[(i+a) mod N]; left is d[(i-a) mod N].
  function automatic logic [N-1:0] ref_rot(input logic [N-1:0] d, input int a, input bit left);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++)
      r[i] = left ? d[((i - a) % N + N) % N] : d[(i + a) % N];
    return r;
  endfunction

  // Drive one cycle's inputs at the falling edge and report what the next rising edge transfers.
  task automatic drive(input bit v, input logic [N-1:0] d, input logic [2:0] a, input bit dr,
                       input bit ordy, output bit acc, output bit take, output logic [N-1:0] od);
    @(negedge clk);
    in_valid = v; in_data = d; in_amt = a; in_dir = dr; out_ready = ordy;
    #1;
    acc  = v && in_ready;
    take = out_valid && ordy;
    od   = out_data;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got %h want 00", out_data); end
    if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [N-1:0] dv [4] = '{8'h81, 8'hA5, 8'h01, 8'h01};
    logic [2:0]   av [4] = '{3'd1, 3'd0, 3'd7, 3'd3};
    logic [N-1:0] ev [4] = '{8'hC0, 8'hA5, 8'h02, 8'h20};
    bit acc, take;
    logic [N-1:0] od;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, dv[k], av[k], 1'b0, 1'b1, acc, take, od);
      vectors++;
      if (acc !== 1'b1) begin miscompares++; $display("FAIL dir_accept[%0d] got %b want 1", k, acc); end
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
      vectors += 2;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dir_early_valid[%0d] got %b want 0", k, out_valid); end
      if (count !== 3'd1) begin miscompares++; $display("FAIL dir_count[%0d] got %0d want 1", k, count); end
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
      vectors += 2;
      if (take !== 1'b1) begin miscompares++; $display("FAIL dir_latency[%0d] out_valid got %b want 1", k, out_valid); end
      if (od !== ev[k]) begin miscompares++; $display("FAIL dir_data[%0d] got %h want %h", k, od, ev[k]); end
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
    end
  endtask

  task automatic test_left;
`ifdef ROT_STREAM_LEFT_EN
    bit acc, take;
    logic [N-1:0] od;
    logic [N-1:0] ev [2] = '{8'h08, 8'h20};
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 8'h01, 3'd3, (k == 0), 1'b1, acc, take, od);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
      vectors++;
      if (!take || od !== ev[k]) begin miscompares++; $display("FAIL left_dir[%0d] got %h valid %b want %h", k, od, take, ev[k]); end
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
    end
`endif
  endtask

  task automatic test_backpressure;
    bit acc, take;
    logic [N-1:0] od, d, first;
    int naccept = 0;
    for (int k = 0; k < 6; k++) begin
      d = N'($urandom);
      drive(1'b1, d, 3'(k), 1'b0, 1'b0, acc, take, od);
      if (acc) begin naccept++; q.push_back(ref_rot(d, k, 1'b0)); end
      if (k == 2) first = od;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, acc, take, od);
    vectors += 5;
    if (naccept != 5) begin miscompares++; $display("FAIL bp_accepted got %0d want 5", naccept); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    if (count !== 3'd4) begin miscompares++; $display("FAIL bp_count got %0d want 4", count); end
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
    if (od !== first || od !== q[0]) begin miscompares++; $display("FAIL bp_stable got %h want %h", od, q[0]); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
      vectors++;
      if (!take) begin miscompares++; $display("FAIL bp_b2b[%0d] got no result want one", k); end
      else begin
        if (od !== q[0]) begin miscompares++; $display("FAIL bp_order[%0d] got %h want %h", k, od, q[0]); end
        void'(q.pop_front());
      end
    end
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL bp_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_stream;
    bit acc, take;
    logic [N-1:0] od, d;
    logic [2:0] a;
    for (int k = 0; k < 20; k++) begin
      d = N'($urandom); a = 3'($urandom);
      drive(k < 16, d, a, 1'b0, 1'b1, acc, take, od);
      if (acc) q.push_back(ref_rot(d, a, 1'b0));
      if (k >= 1 && k < 16) begin
        vectors++;
        if (count !== 3'd1) begin miscompares++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
      end
      if (k >= 2 && k < 18) begin
        vectors++;
        if (!take) begin miscompares++; $display("FAIL stream_rate[%0d] got no result want one", k); end
      end
      if (take) begin
        vectors++;
        if (q.size() == 0 || od !== q[0]) begin miscompares++; $display("FAIL stream_data[%0d] got %h want %h", k, od, q.size() ? q[0] : 8'hxx); end
        if (q.size() != 0) void'(q.pop_front());
      end
    end
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL stream_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_random;
    bit acc, take, dr;
    logic [N-1:0] od, d;
    logic [2:0] a;
    for (int k = 0; k < 340; k++) begin
      d = N'($urandom); a = 3'($urandom); dr = 1'($urandom);
      drive((k < 300) && ($urandom_range(0, 1) == 1), d, a, dr,
            (k >= 300) || ($urandom_range(0, 3) != 0), acc, take, od);
      if (acc) q.push_back(ref_rot(d, a, dr && LEFT_EN));
      if (take) begin
        vectors++;
        if (q.size() == 0 || od !== q[0]) begin miscompares++; $display("FAIL rand_data[%0d] got %h want %h", k, od, q.size() ? q[0] : 8'hxx); end
        if (q.size() != 0) void'(q.pop_front());
      end
    end
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL rand_drain got %0d left want 0", q.size()); end
  endtask

  task automatic test_reset_midflight;
    bit acc, take;
    logic [N-1:0] od, d;
    for (int k = 0; k < 4; k++) begin
      d = N'($urandom);
      drive(1'b1, d, 3'd2, 1'b0, 1'b0, acc, take, od);
      if (acc) q.push_back(ref_rot(d, 2, 1'b0));
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, acc, take, od);
    vectors++;
    if (count !== 3'd3 || out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_pre got count %0d valid %b want 3 1", count, out_valid); end
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_mid_data got %h want 00", out_data); end
    if (count !== 3'd0) begin miscompares++; $display("FAIL rst_mid_count got %0d want 0", count); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    q.delete();
    in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; in_dir = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b1;
    q.push_back(8'hC0);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (count !== 3'd1) begin miscompares++; $display("FAIL rst_first_accept count got %0d want 1", count); end
    for (int k = 0; k < 6 && q.size() != 0; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, acc, take, od);
      if (take) begin
        vectors++;
        if (od !== q[0]) begin miscompares++; $display("FAIL rst_after_data got %h want %h", od, q[0]); end
        void'(q.pop_front());
      end
    end
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL rst_after_drain got %0d left want 0", q.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_left();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rot_stream.md
ROT_STREAM -- requirements
Module: rot_stream

Interface
REQ-001 Parameter N, default 8: data width; SHALL be a power of 2, N >= 2.
REQ-002 Parameter DEPTH, default 4: command FIFO depth; SHALL be a power of 2, DEPTH >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream command valid.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 in_data  input  N  word to rotate.
REQ-008 in_amt  input  $clog2(N)  rotate amount, 0..N-1.
REQ-009 out_valid  output  1  out_data holds a result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_data  output  N  rotated word.
REQ-012 count  output  $clog2(DEPTH)+1  current FIFO occupancy; excludes the output register.

Function
REQ-013 Transfers SHALL occur only on a clock edge with valid and ready both high; the input side is in_valid && in_ready, the output side is out_valid && out_ready.
REQ-014 Accepted {in_data, in_amt} pairs SHALL be stored in a DEPTH-entry circular FIFO with wrap-around read and write pointers.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL be registered-state based; it SHALL NOT depend combinationally on in_valid or out_ready.
REQ-016 The FIFO head SHALL feed a combinational rotate core; out_data = in_data rotated right by in_amt, with bit i of the result equal to in_data[(i+in_amt) mod N].
REQ-017 The output register SHALL load the rotated head and pop the FIFO when FIFO non-empty && (!out_valid || out_ready).
REQ-018 out_valid SHALL clear when out_valid && out_ready and no new load occurs in that cycle.
REQ-019 Latency: a command accepted at edge t into an empty block SHALL appear with out_valid high after edge t+1.
REQ-020 Throughput: one result per cycle SHALL be sustained while in_valid and out_ready stay high.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged.
REQ-022 While out_valid && !out_ready, out_data and out_valid SHALL remain stable.
REQ-023 Results SHALL leave the block in acceptance order, with none lost or duplicated.
REQ-024 in_amt = 0 SHALL pass in_data unchanged.

Reset
REQ-025 On rst_n low, out_valid = 0, out_data = 0, count = 0, both pointers = 0, and in_ready = 1, all asynchronously.
REQ-026 Reset during operation SHALL discard all queued and in-flight commands.
REQ-027 The first acceptance after reset SHALL be possible at the first clk edge with rst_n high.

Configuration
REQ-028 With macro ROT_STREAM_LEFT_EN defined, an input port in_dir (1 bit) SHALL exist and be stored per FIFO entry: 0 = rotate right, 1 = rotate left by in_amt.
REQ-029 Without ROT_STREAM_LEFT_EN, port in_dir SHALL be absent and all commands SHALL rotate right.

Structure
REQ-030 Shared package rot_pkg SHALL hold the default-width constants and the rotate-direction enum typedef (ROT_RIGHT, ROT_LEFT).
REQ-031 Sub-module rot_core (parameter N, purely combinational rotate-right) SHALL implement the rotation.
REQ-032 Left rotation SHALL be implemented in rot_stream as a right rotation by (N - in_amt) mod N.

Verification (N=8, DEPTH=4)
REQ-033 Send 8'b1000_0001 with amt 1 -> out_data 8'b1100_0000 with out_valid high two edges after acceptance.
REQ-034 Send 8'hA5 with amt 0 -> out_data 8'hA5; send 8'h01 with amt 7 -> out_data 8'h02.
REQ-035 Hold out_ready=0 and offer 6 commands -> 5 accepted, in_ready low after the 5th, count = 4, out_data stable; then set out_ready=1 -> 5 results appear in order, back-to-back.
REQ-036 Stream 16 random commands with in_valid and out_ready at 100% -> one result per cycle and count constant after fill.
REQ-037 Assert rst_n low with count = 3 and out_valid high -> out_valid, out_data and count are 0 immediately; the next command is accepted normally.
REQ-038 With ROT_STREAM_LEFT_EN defined, send 8'h01 with amt 3 and in_dir=1 -> 8'h08; the same command with in_dir=0 -> 8'h20.
